// File: rtl/s32c_pkg.sv
// s32c shared types: default datapath width and the status flag bundle
// carried alongside the registered sum.
package s32c_pkg;

  localparam int S32C_WIDTH = 32;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } s32c_flags_t;

endpackage

// File: rtl/s32c_cla4.sv
// s32c_cla4: 4-bit carry-lookahead adder slice.
// Ports: a,b,cin in; s sum, cout carry-out, p/g block propagate/generate out.
module s32c_cla4
  import s32c_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       p,
  output logic       g
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign p = &w_p;
  assign g = w_g[3] | (w_p[3] & w_g[2])
           | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

  assign cout = g | (p & cin);
  assign s    = w_p ^ w_c;

endmodule

// File: rtl/s32c.sv
// s32c: registered WIDTH-bit adder, C = A + B, with carry/ovf/zero/neg.
// Ports: clk, rst (sync high), in_valid, A, B in; C, flags, out_valid out.
module s32c
  import s32c_pkg::*;
#(
  parameter int WIDTH = S32C_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             out_valid
);

  localparam int NB = WIDTH / 4;

  logic [WIDTH-1:0] w_sum;
  logic [NB:0]      w_c;
  logic [NB-1:0]    w_cout;
  logic [NB-1:0]    w_bp;
  logic [NB-1:0]    w_bg;
  logic [NB:0]      w_gg;
  s32c_flags_t      w_flags;

  logic [WIDTH-1:0] r_c;
  s32c_flags_t      r_flags;
  logic             r_valid;

  assign w_c[0]  = 1'b0;
  assign w_gg[0] = 1'b0;

  // Blocks ripple into each other through cout; the block p/g fold
  // gives the final carry-out independently of the last sum slice.
  for (genvar i = 0; i < NB; i++) begin : g_blk
    s32c_cla4 u_cla4 (
      .a    (A[4*i +: 4]),
      .b    (B[4*i +: 4]),
      .cin  (w_c[i]),
      .s    (w_sum[4*i +: 4]),
      .cout (w_cout[i]),
      .p    (w_bp[i]),
      .g    (w_bg[i])
    );
    assign w_c[i+1]  = w_cout[i];
    assign w_gg[i+1] = w_bg[i] | (w_bp[i] & w_gg[i]);
  end

  always_comb begin
    w_flags       = '0;
    w_flags.carry = w_gg[NB];
    w_flags.ovf   = (A[WIDTH-1] == B[WIDTH-1])
                  && (w_sum[WIDTH-1] != A[WIDTH-1]);
    w_flags.zero  = (w_sum == '0);
    w_flags.neg   = w_sum[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c     <= '0;
      r_flags <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_c     <= w_sum;
        r_flags <= w_flags;
      end
    end
  end

  assign C         = r_c;
  assign carry     = r_flags.carry;
  assign ovf       = r_flags.ovf;
  assign zero      = r_flags.zero;
  assign neg       = r_flags.neg;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_s32c.sv
// tb_s32c: directed table-driven bench for the s32c registered adder.
// Checks reset, flag boundaries, streaming, idle hold and mid-stream reset.
module tb_s32c;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] C;
  logic        carry;
  logic        ovf;
  logic        zero;
  logic        neg;
  logic        out_valid;

  int n_chk;
  int n_pass;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        cy;
    logic        ov;
    logic        zr;
    logic        ng;
  } vec_t;

  vec_t tbl[12];

  s32c u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .C         (C),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       name,
    input logic [31:0] ec,
    input logic        ecy,
    input logic        eov,
    input logic        ezr,
    input logic        eng,
    input logic        evl
  );
    logic [36:0] act;
    logic [36:0] exp;
    act = {C, carry, ovf, zero, neg, out_valid};
    exp = {ec, ecy, eov, ezr, eng, evl};
    n_chk++;
    if (act === exp) n_pass++;
    else
      $display("FAIL %s: got C=%h cy=%b ov=%b z=%b n=%b v=%b, want C=%h cy=%b ov=%b z=%b n=%b v=%b",
               name, C, carry, ovf, zero, neg, out_valid,
               ec, ecy, eov, ezr, eng, evl);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] m;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] last_c;
    logic        last_cy;
    logic        last_ov;
    logic        last_zr;
    logic        last_ng;
    logic        mov;

    n_chk    = 0;
    n_pass   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;

    tbl[0]  = '{32'd10, 32'd5, 32'd15, 0, 0, 0, 0};
    tbl[1]  = '{32'd99999, 32'd11111, 32'd111110, 0, 0, 0, 0};
    tbl[2]  = '{32'hFFFFFFFF, 32'd1, 32'd0, 1, 0, 1, 0};
    tbl[3]  = '{32'd0, 32'd0, 32'd0, 0, 0, 1, 0};
    tbl[4]  = '{32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 1, 0, 1};
    tbl[5]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFE, 1, 0, 0, 0};
    tbl[6]  = '{32'h80000000, 32'd1, 32'h80000001, 0, 0, 0, 1};
    tbl[7]  = '{32'h80000000, 32'h80000000, 32'd0, 1, 1, 1, 0};
    tbl[8]  = '{-32'd123456, -32'd654321, 32'hFFF421CF, 1, 0, 0, 1};
    tbl[9]  = '{-32'd100, 32'd50, 32'hFFFFFFCE, 0, 0, 0, 1};
    tbl[10] = '{32'h0F0F0F0F, 32'h00F0F0F1, 32'h10000000, 0, 0, 0, 0};
    tbl[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0, 0, 1};

    tick();
    check("reset1", 0, 0, 0, 0, 0, 0);
    tick();
    check("reset2", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      A        = tbl[i].a;
      B        = tbl[i].b;
      in_valid = 1'b1;
      tick();
      check($sformatf("vec%0d", i), tbl[i].c, tbl[i].cy,
            tbl[i].ov, tbl[i].zr, tbl[i].ng, 1'b1);
    end

    last_c  = '0;
    last_cy = 1'b0;
    last_ov = 1'b0;
    last_zr = 1'b0;
    last_ng = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 3) rb = -ra;
      if (i == 7) rb = 32'h80000000 - ra;
      A  = ra;
      B  = rb;
      m   = {1'b0, ra} + {1'b0, rb};
      mov = (ra[31] == rb[31]) && (m[31] != ra[31]);
      tick();
      check($sformatf("stream%0d", i), m[31:0], m[32], mov,
            m[31:0] == 32'd0, m[31], 1'b1);
      last_c  = m[31:0];
      last_cy = m[32];
      last_ov = mov;
      last_zr = (m[31:0] == 32'd0);
      last_ng = m[31];
    end

    in_valid = 1'b0;
    A        = 32'h12345678;
    B        = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold%0d", i), last_c, last_cy,
            last_ov, last_zr, last_ng, 1'b0);
    end

    A        = 32'd5000;
    B        = 32'd1234;
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    check("midreset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    check("after_reset", 32'd6234, 0, 0, 0, 0, 1'b1);
    in_valid = 1'b0;
    tick();
    check("after_idle", 32'd6234, 0, 0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
